// File: rtl/data_memory_hs.sv
// Byte-addressed data memory with valid/ready request, fixed response latency and sign/zero-extending loads.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned accesses return resp_err instead of being force-aligned.
module data_memory_hs #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int AU    = LB + IDX_W;
  localparam int CNT_W = $clog2(LATENCY + 1);

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_accept, w_commit;

  logic               r_write, r_signed;
  logic [1:0]         r_size;
  logic [AU-1:0]      r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_err;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               w_op_write, w_op_signed;
  logic [1:0]         w_op_size;
  logic [AU-1:0]      w_op_addr;
  logic [DATA_W-1:0]  w_op_wdata;
  logic [IDX_W-1:0]   w_idx;
  logic [LB-1:0]      w_off, w_lowmask, w_off_al;
  logic               w_misal, w_rsvd, w_err;
  logic [NB-1:0]      w_be;
  logic [DATA_W-1:0]  w_wsh, w_word, w_rsh;

  // Narrow a right-aligned lane of 8<<sz bits back out to DATA_W.
  function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] v,
                                                 input logic [1:0] sz,
                                                 input logic sgn);
    int                nbits;
    logic              s;
    logic [DATA_W-1:0] r;
    nbits = 8 << sz;
    if (nbits >= DATA_W) return v;
    s = sgn & v[nbits-1];
    for (int i = 0; i < DATA_W; i++) r[i] = (i < nbits) ? v[i] : s;
    return r;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_state_nxt = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With LATENCY==1 the access happens on the acceptance edge, so use the live request then.
  always_comb begin
    w_op_write  = (r_state == S_IDLE) ? req_write        : r_write;
    w_op_signed = (r_state == S_IDLE) ? req_signed       : r_signed;
    w_op_size   = (r_state == S_IDLE) ? req_size         : r_size;
    w_op_addr   = (r_state == S_IDLE) ? req_addr[AU-1:0] : r_addr;
    w_op_wdata  = (r_state == S_IDLE) ? req_wdata        : r_wdata;
    w_idx       = w_op_addr[AU-1:LB];
    w_off       = w_op_addr[LB-1:0];
    w_lowmask   = LB'((32'd1 << w_op_size) - 32'd1);
    w_misal     = |(w_off & w_lowmask);
    w_off_al    = w_off & ~w_lowmask;
    w_rsvd      = (DATA_W == 32) && (w_op_size == 2'b11);
    w_err       = w_rsvd || (TRAP && w_misal);
    w_be        = NB'(((32'd1 << (32'd1 << w_op_size)) - 32'd1) << w_off_al);
    w_wsh       = w_op_wdata << {w_off_al, 3'b000};
    w_word      = r_mem[w_idx];
    w_rsh       = w_word >> {w_off_al, 3'b000};
    w_commit    = (w_state_nxt == S_RESP) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_op_write || w_err) ? '0 : f_extend(w_rsh, w_op_size, w_op_signed);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write  <= req_write;
      r_signed <= req_signed;
      r_size   <= req_size;
      r_addr   <= req_addr[AU-1:0];
      r_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_op_write && !w_err) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs: vector table on a LATENCY=2 instance plus
// back-to-back and reset-abort sequences (second instance with LATENCY=3).
module tb_data_memory_hs;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed, resp_valid, resp_err, busy;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata;

  logic        b_valid, b_ready, b_write, b_signed, b_resp_valid, b_err, b_busy;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  data_memory_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy));

  data_memory_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_size(b_size), .req_signed(b_signed),
    .req_addr(b_addr), .req_wdata(b_wdata), .resp_valid(b_resp_valid),
    .resp_rdata(b_rdata), .resp_err(b_err), .busy(b_busy));

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output int lat, output logic pulse_ok);
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    pulse_ok = !resp_valid && req_ready;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er, pok, seen;
    int          lat, nresp;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h11,  32'h80,       32'h0,        1'b0};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h11,  32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h12,  32'h1234,     32'h0,        1'b0};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'h00001234, 1'b0};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h123480EF, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h11,  32'h0,        TRAP ? 32'h0 : 32'h123480EF, TRAP};
    vecs[10] = '{1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        32'h00000012, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 1'b1, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0};
    vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h10,  32'h0,        32'hFFFF80EF, 1'b0};
    vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h10,  32'h0,        32'h000080EF, 1'b0};
    vecs[14] = '{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1};
    vecs[15] = '{1'b1, 2'b11, 1'b0, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h123480EF, 1'b0};
    vecs[17] = '{1'b1, 2'b01, 1'b0, 32'h13,  32'hAAAA,     32'h0,        TRAP};
    vecs[18] = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        TRAP ? 32'h123480EF : 32'hAAAA80EF, 1'b0};
    vecs[19] = '{1'b1, 2'b10, 1'b0, 32'h414, 32'h55667788, 32'h0,        1'b0};
    vecs[20] = '{1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        32'h55667788, 1'b0};
    vecs[21] = '{1'b1, 2'b00, 1'b0, 32'h16,  32'h1FF,      32'h0,        1'b0};
    vecs[22] = '{1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        32'h55FF7788, 1'b0};
    vecs[23] = '{1'b0, 2'b01, 1'b1, 32'h16,  32'h0,        32'h000055FF, 1'b0};
    vecs[24] = '{1'b0, 2'b00, 1'b1, 32'h16,  32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[25] = '{1'b0, 2'b00, 1'b0, 32'h17,  32'h0,        32'h00000055, 1'b0};

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_size = 2'b10; b_signed = 1'b0;
    b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_ready",  64'(req_ready),  64'd1);
    check("reset_busy",   64'(busy),       64'd0);
    check("reset_rvalid", 64'(resp_valid), 64'd0);
    check("reset_rdata",  64'(resp_rdata), 64'd0);
    check("reset_err",    64'(resp_err),   64'd0);
    check("reset_l3_rdy", 64'(b_ready),    64'd1);

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd, rd, er, lat, pok);
      check($sformatf("vec%0d_rdata", i),   64'(rd),  64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_err", i),     64'(er),  64'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d_pulse", i),   64'(pok), 64'd1);
    end

    // Back-to-back on the LATENCY=3 instance: one accept every 4 cycles.
    @(negedge clk);
    b_valid = 1'b1;
    nresp = 0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("l3_busy_c%0d", k),  64'(b_busy),       64'(k % 4 != 0));
      check($sformatf("l3_rvalid_c%0d", k), 64'(b_resp_valid), 64'(k % 4 == 3));
      if (b_resp_valid) nresp++;
      @(negedge clk);
    end
    b_valid = 1'b0;
    check("l3_resp_count", 64'(nresp), 64'd4);

    // Reset during WAIT drops the store and clears the outputs.
    do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, rd, er, lat, pok);
    check("pre_store_err", 64'(er), 64'd0);
    do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, pok);
    check("pre_load_rdata", 64'(rd), 64'hCAFEF00D);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h11111111;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_in_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    seen = resp_valid;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    check("abort_no_resp", 64'(seen),       64'd0);
    check("abort_rdata",   64'(resp_rdata), 64'd0);
    check("abort_err",     64'(resp_err),   64'd0);
    check("abort_ready",   64'(req_ready),  64'd1);
    do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, pok);
    check("abort_kept_data", 64'(rd), 64'hCAFEF00D);
    do_op(1'b0, 2'b10, 1'b0, 32'h410, 32'h0, rd, er, lat, pok);
    check("alias_load", 64'(rd), TRAP ? 64'h123480EF : 64'hAAAA80EF);
    check("alias_err",  64'(er), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
